// File: rtl/dmio_mmap.sv
// Memory-mapped word memory plus a small IO block: output registers, synchronized
// inputs with sticky change flags, and a level interrupt.
module dmio_mmap #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned IO_BIT  = 12,
  parameter int unsigned NUM_OUT = 2,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned NUM_IN  = 2,
  parameter int unsigned IN_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     mem_wr,
  input  logic [NUM_IN*IN_W-1:0]   sw_in,
  output logic [NUM_OUT*OUT_W-1:0] led_out,
  output logic [DATA_W-1:0]        rdata,
  output logic                     irq
);

  logic [DATA_W-1:0] mem [2**MEM_AW];

  logic              io_sel;
  logic              io_wr;
  logic [1:0]        bank;
  logic [2:0]        idx;
  logic [MEM_AW-1:0] mem_idx;

  logic [NUM_OUT*OUT_W-1:0] out_reg;
  logic [NUM_IN*IN_W-1:0]   sync1;
  logic [NUM_IN*IN_W-1:0]   sync2;
  logic [NUM_IN*IN_W-1:0]   prev;
  logic [NUM_IN-1:0]        flags;
  logic [NUM_IN-1:0]        irq_en;
  logic [NUM_IN-1:0]        chg;
  logic [NUM_IN-1:0]        w1c;

  // Only a handful of address bits participate in decode; the rest are don't-care.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign io_sel  = addr[IO_BIT];
  assign io_wr   = mem_wr & io_sel;
  assign bank    = addr[5:4];
  assign idx     = addr[2:0];
  assign mem_idx = addr[MEM_AW-1:0];

  // Memory is deliberately outside the reset domain: contents survive rst and
  // a write issued during rst still lands.
  always_ff @(posedge clk) begin
    if (mem_wr && !io_sel) begin
      mem[mem_idx] <= wdata;
    end
  end

  always_comb begin
    chg = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      chg[i] = sync2[i*IN_W +: IN_W] != prev[i*IN_W +: IN_W];
    end
  end

  assign w1c = (io_wr && bank == 2'b10 && idx == 3'd0) ? wdata[NUM_IN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= '0;
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      flags   <= '0;
      irq_en  <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      prev  <= sync2;
      // Set dominates clear when detection and W1C land on the same edge.
      flags <= (flags & ~w1c) | chg;
      if (io_wr && bank == 2'b10 && idx == 3'd1) begin
        irq_en <= wdata[NUM_IN-1:0];
      end
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        if (io_wr && bank == 2'b00 && 32'(idx) == i) begin
          out_reg[i*OUT_W +: OUT_W] <= wdata[OUT_W-1:0];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (!io_sel) begin
      rdata = mem[mem_idx];
    end else begin
      case (bank)
        2'b00: begin
          for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (32'(idx) == i) rdata[OUT_W-1:0] = out_reg[i*OUT_W +: OUT_W];
          end
        end
        2'b01: begin
          for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(idx) == i) rdata[IN_W-1:0] = sync2[i*IN_W +: IN_W];
          end
        end
        2'b10: begin
          if (idx == 3'd0) begin
            rdata[NUM_IN-1:0] = flags;
          end else if (idx == 3'd1) begin
            rdata[NUM_IN-1:0] = irq_en;
          end
        end
        default: ;
      endcase
    end
  end

  assign led_out = out_reg;
  assign irq     = |(flags & irq_en);

endmodule

// File: doc/dmio_mmap.md
DMIO_MMAP -- requirements
Module: dmio_mmap

Interface
REQ-001 Parameter DATA_W, default 64, shall set the bus data width.
REQ-002 Parameter ADDR_W, default 64, shall set the bus address width.
REQ-003 Parameter MEM_AW, default 12, shall set the memory index width; depth is 2^MEM_AW words.
REQ-004 Parameter IO_BIT, default 12, shall set the IO-select address bit; legal only when IO_BIT >= MEM_AW and IO_BIT >= 6.
REQ-005 Parameter NUM_OUT, default 2, range 1..8, shall set the output channel count.
REQ-006 Parameter OUT_W, default 8, range 1..DATA_W, shall set the output channel width.
REQ-007 Parameter NUM_IN, default 2, range 1..8, shall set the input channel count.
REQ-008 Parameter IN_W, default 8, range 1..DATA_W, shall set the input channel width.
REQ-009 Port list: clk, in, 1, single clock; all state updates on its rising edge.
REQ-010 Port list: rst, in, 1, synchronous active-high reset.
REQ-011 Port list: addr, in, ADDR_W, word address.
REQ-012 Port list: wdata, in, DATA_W, write data.
REQ-013 Port list: mem_wr, in, 1, write strobe.
REQ-014 Port list: sw_in, in, NUM_IN*IN_W, asynchronous inputs; channel i occupies bits [i*IN_W +: IN_W].
REQ-015 Port list: led_out, out, NUM_OUT*OUT_W, output registers; channel i occupies bits [i*OUT_W +: OUT_W].
REQ-016 Port list: rdata, out, DATA_W, combinational read data.
REQ-017 Port list: irq, out, 1, level interrupt.

Function
REQ-018 Decode: addr[IO_BIT]=0 shall select memory at index addr[MEM_AW-1:0]; addr[IO_BIT]=1 shall select IO space, with bank = addr[5:4] and idx = addr[2:0].
REQ-019 Memory shall write wdata at the rising edge when mem_wr=1 and addr[IO_BIT]=0; memory shall never be written while IO is selected.
REQ-020 Memory read shall be asynchronous: rdata = mem[index] in the same cycle, and a read of an address written in that cycle shall return the old data.
REQ-021 Bank 00 (outputs): idx < NUM_OUT shall be read/write, with write storing wdata[OUT_W-1:0] into out_reg[idx] at the edge and led_out driven directly from out_reg.
REQ-022 Bank 01 (inputs): idx < NUM_IN shall be read-only, returning the synchronized value sync2[idx]; writes shall be ignored.
REQ-023 Bank 10, idx 0 shall be STATUS: NUM_IN sticky change flags, bit i for channel i; writing 1 to bit i shall clear flag i (W1C), and writing 0 shall leave it unchanged.
REQ-024 Bank 10, idx 1 shall be IRQ_EN: NUM_IN read/write bits.
REQ-025 Bank 11, any idx >= channel count, and any other bank-10 idx shall be reserved: reads return 0 and writes are ignored.
REQ-026 All IO reads shall be zero-extended to DATA_W.
REQ-027 Synchronizer: per channel, sync1 <= sw_in and sync2 <= sync1 every cycle (2-flop); prev <= sync2 every cycle.
REQ-028 A change on channel i is detected when sync2[i] != prev[i] (any bit); flag i shall be set at that edge.
REQ-029 Latency: a sw_in change ahead of edge E shall be readable in bank 01 after edge E+1, and flag i shall be set after edge E+2.
REQ-030 When a change is detected and a W1C of the same bit occur in the same cycle, set shall win and the flag shall remain 1.
REQ-031 irq shall be combinational: irq = OR over i of (flag[i] & irq_en[i]); it shall hold until flags are cleared or enables are dropped.
REQ-032 A change that occurs while a flag is already set shall leave it at 1, with no counting.

Reset
REQ-033 When rst=1 at an edge, the following shall be 0 after that edge: out_reg (led_out=0), sync1, sync2, prev, flags, irq_en, and hence irq=0.
REQ-034 rst shall take priority over any simultaneous write or change detection.
REQ-035 Memory contents shall not be affected by rst; a write with mem_wr=1 during rst shall still complete.
REQ-036 Because prev and sync2 both reset to 0, a sw_in value held nonzero through reset shall set its flag after release per REQ-029 latency.

Verification
REQ-037 Memory: write 0xDEADBEEF_CAFEF00D to word 5, then read word 5 -> rdata = that value; read word 6 (unwritten) -> no X from logic under test.
REQ-038 IO isolation: write 0xAB to addr 0x1000 (bank 00, idx 0) -> led_out[7:0]=0xAB, memory word 0 unchanged; write to addr 0x1003 -> ignored, read 0x1003 -> 0.
REQ-039 Input path: drive sw_in ch1=0x5A -> read 0x1011 returns 0x5A two edges later, and STATUS bit1=1 one edge after that.
REQ-040 Interrupt: with IRQ_EN=0b10 and flag1 set -> irq=1; write STATUS 0b10 -> irq=0 next cycle; repeat with a change coincident with the W1C -> flag stays 1.
REQ-041 Reset mid-operation: led_out=0xFF, flags=0b11, irq=1, then rst pulse -> all zero after one edge while a previously written memory word still reads back intact.
